seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver for an N-digit common-anode display. It latches an N-nibble hex word plus per-digit point and blank flags, then scans one digit at a time at a programmable refresh rate. It drives registered, active-low anode and segment lines. It replaces single-digit combinational decoding in the board-level display path and sits between the datapath, which supplies the value, and the FPGA pins.

---
 rtl/seg7_scan_driver.sv | 159 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver for an N-digit common-anode display.
// A latched hex word is scanned one digit at a time, with registered active-low anode and segment outputs.
module seg7_scan_driver #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   hex,
  input  logic [DIGITS-1:0]     points,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  le,
  input  logic                  lzb,
  input  logic                  lt,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      4'hF:    pat = 7'b0001110;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  logic [4*DIGITS-1:0] r_hex;
  logic [DIGITS-1:0]   r_pt;
  logic [DIGITS-1:0]   r_blk;
  logic [PRE_W-1:0]    r_pre;
  logic [IDX_W-1:0]    r_idx;
  logic [DIGITS-1:0]   r_an;
  logic [7:0]          r_seg;

  logic                w_tc;
  logic [DIGITS-1:0]   w_lz_mask;
  logic [3:0]          w_nib;
  logic                w_pt;
  logic                w_blk;
  logic                w_sup;
  logic [DIGITS-1:0]   w_an_sel;
  logic [DIGITS-1:0]   w_an_nxt;
  logic [7:0]          w_seg_nxt;

  // Display register: transparent while le is low; blank flags reset high so nothing lights before the first capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hex <= '0;
      r_pt  <= '0;
      r_blk <= '1;
    end else if (!le) begin
      r_hex <= hex;
      r_pt  <= points;
      r_blk <= blank;
    end
  end

  assign w_tc = (r_pre == PRE_LAST);

  // Prescaler and scan index; idx advances on the prescaler terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_idx <= '0;
    end else begin
      r_pre <= w_tc ? '0 : (r_pre + PRE_W'(1));
      if (w_tc) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : (r_idx + IDX_W'(1));
      end
    end
  end

  // Leading-zero mask: bit i set when nibbles i..DIGITS-1 are all zero; digit 0 is never suppressed.
  always_comb begin
    logic v_run;
    v_run     = 1'b1;
    w_lz_mask = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v_run        = v_run & (r_hex[4*i +: 4] == 4'h0);
      w_lz_mask[i] = v_run;
    end
    w_lz_mask[0] = 1'b0;
  end

  // Select the attributes of the digit currently being scanned.
  always_comb begin
    w_nib    = 4'h0;
    w_pt     = 1'b0;
    w_blk    = 1'b0;
    w_sup    = 1'b0;
    w_an_sel = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_hex[4*i +: 4];
        w_pt        = r_pt[i];
        w_blk       = r_blk[i];
        w_sup       = w_lz_mask[i];
        w_an_sel[i] = 1'b0;
      end else begin
        w_an_sel[i] = 1'b1;
      end
    end
  end

  // Output priority: lamp test, then explicit blank, then leading-zero suppression, then decode.
  always_comb begin
    w_an_nxt  = '1;
    w_seg_nxt = 8'hFF;
    if (lt) begin
      w_an_nxt  = w_an_sel;
      w_seg_nxt = 8'h00;
    end else if (w_blk) begin
      w_an_nxt  = '1;
      w_seg_nxt = 8'hFF;
    end else if (lzb && w_sup) begin
      w_an_nxt  = w_an_sel;
      w_seg_nxt = {~w_pt, 7'b1111111};
    end else begin
      w_an_nxt  = w_an_sel;
      w_seg_nxt = {~w_pt, seg7_decode(w_nib)};
    end
  end

  // Registered pin drivers; anode and segments update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= '1;
      r_seg <= 8'hFF;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised and directed bench for seg7_scan_driver (4-digit scan plus a 1-digit, every-cycle instance).
module tb_seg7_scan_driver;

  localparam int D = 4;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] hex = 16'h1234;
  logic [3:0]  points = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic        le = 1'b0;
  logic        lzb = 1'b0;
  logic        lt = 1'b0;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [0:0]  an1;
  logic [7:0]  seg1;

  int checks = 0;
  int failures = 0;

  logic [6:0] dec_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // model state: display register contents and edges since reset release
  logic [3:0] m_hex [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0] m_pt = 4'h0;
  logic [3:0] m_blk = 4'hF;
  int         cnt = 0;
  logic [3:0] exp_an = 4'hF;
  logic [7:0] exp_seg = 8'hFF;
  logic       exp_an1 = 1'b1;
  logic [7:0] exp_seg1 = 8'hFF;

  seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .hex(hex), .points(points), .blank(blank),
    .le(le), .lzb(lzb), .lt(lt), .an(an), .seg(seg));

  seg7_scan_driver #(.DIGITS(1), .SCAN_DIV(1)) u_one (
    .clk(clk), .rst_n(rst_n), .hex(hex[3:0]), .points(points[0:0]), .blank(blank[0:0]),
    .le(le), .lzb(lzb), .lt(lt), .an(an1), .seg(seg1));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // what the pins must show for scan slot idx of an ndig-digit display
  function automatic logic [11:0] model_out(input int idx, input int ndig);
    logic [3:0] a;
    logic [7:0] s;
    bit         zab;
    zab = 1'b1;
    for (int j = idx; j < ndig; j++) if (m_hex[j] != 4'h0) zab = 1'b0;
    a = 4'hF;
    a[idx] = 1'b0;
    if (lt) s = 8'h00;
    else if (m_blk[idx]) begin
      a = 4'hF;
      s = 8'hFF;
    end
    else if (lzb && idx != 0 && zab) s = {~m_pt[idx], 7'h7F};
    else s = {~m_pt[idx], dec_tab[m_hex[idx]]};
    return {a, s};
  endfunction

  initial forever begin
    logic [11:0] r;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      cnt = 0;
      for (int j = 0; j < 4; j++) m_hex[j] = 4'h0;
      m_pt = 4'h0;
      m_blk = 4'hF;
      exp_an = 4'hF;
      exp_seg = 8'hFF;
      exp_an1 = 1'b1;
      exp_seg1 = 8'hFF;
    end else begin
      r = model_out((cnt / S) % D, D);
      exp_an = r[11:8];
      exp_seg = r[7:0];
      r = model_out(0, 1);
      exp_an1 = r[8];
      exp_seg1 = r[7:0];
      if (!le) begin
        for (int j = 0; j < 4; j++) m_hex[j] = hex[4*j +: 4];
        m_pt = points;
        m_blk = blank;
      end
      cnt++;
    end
  end

  initial forever begin
    @(negedge clk);
    check("an", {28'h0, an}, {28'h0, exp_an});
    check("seg", {24'h0, seg}, {24'h0, exp_seg});
    check("an1", {31'h0, an1}, {31'h0, exp_an1});
    check("seg1", {24'h0, seg1}, {24'h0, exp_seg1});
  end

  task automatic wait_an(input logic [3:0] target, input string name);
    bit found = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (!found) begin
        @(negedge clk);
        if (an === target) found = 1'b1;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s_timeout actual=%b expected=%b", name, an, target);
    end
  endtask

  task automatic wait_not_an(input logic [3:0] target, input string name);
    bit found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (!found) begin
        @(negedge clk);
        if (an !== target) found = 1'b1;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s_timeout actual=%b still=%b", name, an, target);
    end
  endtask

  task automatic random_phase(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      hex = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      points = 4'($urandom);
      blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      le = ($urandom_range(0, 4) == 0);
      lzb = 1'($urandom);
      lt = ($urandom_range(0, 9) == 0);
    end
  endtask

  task automatic set_inputs(input logic [15:0] h, input logic [3:0] p, input logic [3:0] b,
                            input logic l_e, input logic l_z, input logic l_t);
    @(negedge clk);
    hex = h; points = p; blank = b; le = l_e; lzb = l_z; lt = l_t;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_an", {28'h0, an}, 32'hF);
    check("reset_seg", {24'h0, seg}, 32'hFF);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_cycle_dark", {28'h0, an}, 32'hF);
    @(negedge clk);
    check("digit0_an", {28'h0, an}, 32'hE);
    check("digit0_seg", {24'h0, seg}, 32'h99);
    check("pin_model_digit0", {24'h0, exp_seg}, 32'h99);
    wait_an(4'b1101, "scan_d1");
    check("digit1_seg", {24'h0, seg}, 32'hB0);

    random_phase(300);

    // latch: le rises on the same edge hex changes, so 1234 is held
    set_inputs(16'h1234, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    hex = 16'hFFFF;
    le = 1'b1;
    repeat (3) @(negedge clk);
    wait_an(4'b1110, "latch_d0");
    check("latch_hold_d0", {24'h0, seg}, 32'h99);
    wait_an(4'b1101, "latch_d1");
    check("latch_hold_d1", {24'h0, seg}, 32'hB0);
    @(negedge clk);
    le = 1'b0;
    repeat (2) @(negedge clk);
    wait_an(4'b1110, "latch_rel");
    check("latch_release_F", {24'h0, seg}, 32'h8E);

    // decode sweep on the single-digit instance
    for (int v = 0; v < 16; v++) begin
      logic [3:0] nv;
      nv = 4'(v);
      @(negedge clk);
      hex = {nv, nv, nv, nv};
      points = 4'h0; blank = 4'h0; le = 1'b0; lzb = 1'b0; lt = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("sweep_seg1", {24'h0, seg1}, {24'h0, 1'b1, dec_tab[nv]});
    end
    check("sweep_pin_8", {25'h0, dec_tab[8]}, 32'h00);

    // leading-zero blanking
    set_inputs(16'h0040, 4'b1000, 4'h0, 1'b0, 1'b1, 1'b0);
    wait_an(4'b0111, "lzb_d3");
    check("lzb_d3_seg", {24'h0, seg}, 32'h7F);
    check("pin_model_lzb_d3", {24'h0, exp_seg}, 32'h7F);
    wait_an(4'b1110, "lzb_d0");
    check("lzb_d0_seg", {24'h0, seg}, 32'hC0);
    wait_an(4'b1101, "lzb_d1");
    check("lzb_d1_seg", {24'h0, seg}, 32'h99);
    wait_an(4'b1011, "lzb_d2");
    check("lzb_d2_seg", {24'h0, seg}, 32'hFF);
    set_inputs(16'h0000, 4'b1000, 4'h0, 1'b0, 1'b1, 1'b0);
    wait_an(4'b1110, "lzb_zero_d0");
    check("lzb_zero_d0_seg", {24'h0, seg}, 32'hC0);

    // explicit blank, then lamp test overriding it
    set_inputs(16'h1234, 4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0);
    wait_an(4'b1110, "blank_d0");
    wait_not_an(4'b1110, "blank_leave_d0");
    check("blank_an", {28'h0, an}, 32'hF);
    check("blank_seg", {24'h0, seg}, 32'hFF);
    @(negedge clk);
    lt = 1'b1;
    repeat (2) @(negedge clk);
    wait_an(4'b1101, "lt_d1");
    check("lt_d1_seg", {24'h0, seg}, 32'h00);
    @(negedge clk);
    lt = 1'b0;

    // async reset while digit 2 is displayed
    set_inputs(16'h1234, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    wait_an(4'b1011, "rst_d2");
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_an", {28'h0, an}, 32'hF);
    check("async_rst_seg", {24'h0, seg}, 32'hFF);
    check("async_rst_seg1", {24'h0, seg1}, 32'hFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_dark", {28'h0, an}, 32'hF);
    @(negedge clk);
    check("restart_an", {28'h0, an}, 32'hE);
    check("restart_seg", {24'h0, seg}, 32'h99);

    random_phase(200);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
